dvp_tx: RTL and testbench

- DVP transmitter: the camera side of the same interface that DVP_Capture receives. Emits OV5640-style frames:
  - active-high vsync pulse
  - href asserted per active line
  - two bytes per RGB565 pixel, high byte first
- Pixel source is either an upstream valid/ready stream or a built-in 8-colour-bar generator.
- Used as a camera emulator: feeds DVP_Capture and the DDR write path in simulation and on-board bring-up without the OV5640.

---
 rtl/dvp_tx.sv | 185 ++++++++++++++++++
 tb/tb_dvp_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_tx.sv
// DVP camera-side transmitter: OV5640-style vsync/href framing of RGB565 pixels, high byte first,
// sourced from a valid/ready stream or a built-in 8-colour-bar generator.
module dvp_tx #(
   parameter int unsigned H_ACTIVE    = 800,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned H_BLANK     = 160,
   parameter int unsigned VSYNC_LINES = 4,
   parameter int unsigned VBP_LINES   = 16,
   parameter int unsigned VFP_LINES   = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        enable,
   input  logic        pattern_en,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [15:0] pix_data,
   output logic        dvp_vsync,
   output logic        dvp_href,
   output logic [7:0]  dvp_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        underflow,
   output logic        busy
);

   localparam int unsigned LP      = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned VS_LEN  = VSYNC_LINES * LP;
   localparam int unsigned VBP_LEN = VBP_LINES * LP;
   localparam int unsigned VFP_LEN = VFP_LINES * LP;
   localparam int unsigned M1      = (VS_LEN > VBP_LEN) ? VS_LEN : VBP_LEN;
   localparam int unsigned M2      = (M1 > VFP_LEN) ? M1 : VFP_LEN;
   localparam int unsigned CNT_MAX = (M2 > LP) ? M2 : LP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned LINE_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int unsigned BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(VS_LEN - 1);
   localparam logic [CNT_W-1:0]  VBP_LAST  = CNT_W'(VBP_LEN - 1);
   localparam logic [CNT_W-1:0]  VFP_LAST  = CNT_W'(VFP_LEN - 1);
   localparam logic [CNT_W-1:0]  ACT_LAST  = CNT_W'(2 * H_ACTIVE - 1);
   localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

   typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StHblank, StVfp} state_t;

   state_t            r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic [LINE_W-1:0] r_line, w_line_d;
   logic              r_pat, w_pat_d;
   logic [7:0]        r_lo;
   logic              w_ready_d;
   logic [CNT_W-1:0]  w_px;
   logic [2:0]        w_bar;
   logic [15:0]       w_color;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt + 1'b1;
      w_line_d  = r_line;
      w_pat_d   = r_pat;
      case (r_state)
         StIdle: begin
            w_cnt_d = '0;
            if (enable) begin
               w_state_d = StVsync;
               w_pat_d   = pattern_en;
            end
         end
         StVsync: begin
            if (r_cnt == VS_LAST) begin
               w_state_d = StVbp;
               w_cnt_d   = '0;
            end
         end
         StVbp: begin
            if (r_cnt == VBP_LAST) begin
               w_state_d = StActive;
               w_cnt_d   = '0;
               w_line_d  = '0;
            end
         end
         StActive: begin
            if (r_cnt == ACT_LAST) begin
               w_state_d = StHblank;
               w_cnt_d   = '0;
            end
         end
         StHblank: begin
            if (r_cnt == HB_LAST) begin
               w_cnt_d = '0;
               if (r_line == LINE_LAST) begin
                  w_state_d = StVfp;
               end else begin
                  w_state_d = StActive;
                  w_line_d  = r_line + 1'b1;
               end
            end
         end
         StVfp: begin
            if (r_cnt == VFP_LAST) begin
               w_cnt_d = '0;
               if (enable) begin
                  w_state_d = StVsync;
                  w_pat_d   = pattern_en;
               end else begin
                  w_state_d = StIdle;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
   end

   // Request a pixel one cycle ahead of every high-byte slot of the upcoming active line.
   always_comb begin
      w_ready_d = !w_pat_d &&
                  (((w_state_d == StVbp) && (w_cnt_d == VBP_LAST)) ||
                   ((w_state_d == StHblank) && (w_cnt_d == HB_LAST) && (w_line_d != LINE_LAST)) ||
                   ((w_state_d == StActive) && w_cnt_d[0] && (w_cnt_d != ACT_LAST)));
   end

   always_comb begin
      w_px  = w_cnt_d >> 1;
      w_bar = 3'(32'(w_px) / BAR_W);
      case (w_bar)
         3'd0:    w_color = 16'hFFFF;
         3'd1:    w_color = 16'hFFE0;
         3'd2:    w_color = 16'h07FF;
         3'd3:    w_color = 16'h07E0;
         3'd4:    w_color = 16'hF81F;
         3'd5:    w_color = 16'hF800;
         3'd6:    w_color = 16'h001F;
         default: w_color = 16'h0000;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_line      <= '0;
         r_pat       <= 1'b0;
         r_lo        <= '0;
         pix_ready   <= 1'b0;
         dvp_vsync   <= 1'b0;
         dvp_href    <= 1'b0;
         dvp_data    <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         underflow   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_line      <= w_line_d;
         r_pat       <= w_pat_d;
         pix_ready   <= w_ready_d;
         dvp_vsync   <= (w_state_d == StVsync);
         dvp_href    <= (w_state_d == StActive);
         frame_start <= (w_state_d == StVsync) && (w_cnt_d == '0);
         frame_done  <= (w_state_d == StVfp) && (w_cnt_d == VFP_LAST);
         busy        <= (w_state_d != StIdle);
         // A missing pixel is replaced by black without stalling the line.
         if (pix_ready) begin
            r_lo <= pix_valid ? pix_data[7:0] : 8'h00;
            if (!pix_valid) underflow <= 1'b1;
         end
         dvp_data <= '0;
         if (w_state_d == StActive) begin
            if (w_pat_d) begin
               dvp_data <= w_cnt_d[0] ? w_color[7:0] : w_color[15:8];
            end else if (!w_cnt_d[0]) begin
               dvp_data <= (pix_ready && pix_valid) ? pix_data[15:8] : 8'h00;
            end else begin
               dvp_data <= r_lo;
            end
         end
      end
   end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx with a small frame (LP=20, 140-clock frame); a consumer model
// reassembles pixels from bytes sampled away from the active edge.
module tb_dvp_tx;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        enable, pattern_en, pix_valid;
   logic        pix_ready;
   logic [15:0] pix_data;
   logic        dvp_vsync, dvp_href;
   logic [7:0]  dvp_data;
   logic        frame_start, frame_done, underflow, busy;

   int  n_run  = 0;
   int  n_fail = 0;
   bit  auto_inc = 1'b0;

   always #5 Clk = ~Clk;

   dvp_tx #(
      .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .enable(enable), .pattern_en(pattern_en),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
      .frame_start(frame_start), .frame_done(frame_done), .underflow(underflow), .busy(busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   function automatic logic [15:0] bar_color(input int i);
      case (i)
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   // {vsync, href, data[7:0], frame_start, frame_done, busy, pix_ready, underflow}
   function automatic logic [14:0] act_vec();
      return {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy, pix_ready, underflow};
   endfunction

   // Expected outputs at cycle c of a frame (c=0 is the first vsync cycle).
   function automatic logic [14:0] exp_vec(input int c, input bit pat, input int under_pix,
                                           input logic [15:0] base);
      int l, b, p, adj;
      logic vs, hr, act, rdy, uf;
      logic [15:0] px;
      logic [7:0] d;
      vs  = (c < 20);
      act = (c >= 40) && (c < 120);
      l   = act ? (c - 40) / 20 : 0;
      b   = act ? (c - 40) % 20 : 0;
      hr  = act && (b < 16);
      d   = 8'h00;
      if (hr) begin
         if (pat) begin
            px = bar_color(b / 2);
         end else begin
            p   = l * 8 + b / 2;
            adj = (under_pix >= 0 && p > under_pix) ? 1 : 0;
            px  = (p == under_pix) ? 16'h0000 : 16'(int'(base) + p - adj);
         end
         d = (b % 2 == 1) ? px[7:0] : px[15:8];
      end
      rdy = !pat && ((c == 39) || (act && l < 3 && b == 19) || (hr && (b % 2 == 1) && b != 15));
      uf  = (under_pix >= 0) && (c >= 40 + 2 * under_pix);
      return {vs, hr, d, (c == 0), (c == 139), 1'b1, rdy, uf};
   endfunction

   task automatic tick();
      logic xfer;
      xfer = pix_ready && pix_valid;
      @(posedge Clk);
      #1;
      if (xfer && auto_inc) pix_data = pix_data + 16'd1;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0; enable = 1'b0; pattern_en = 1'b0; pix_valid = 1'b0;
      pix_data = 16'h0000; auto_inc = 1'b0;
      tick(); tick();
      Rst_n = 1'b1;
      tick();
   endtask

   task automatic start_frame();
      enable = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; enable = 1'b0; pattern_en = 1'b0; pix_valid = 1'b0; pix_data = 16'h0;
      #1;
      n_run++;
      if (act_vec() !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h, required %h", act_vec(), 15'h0);
      end
      tick();
      Rst_n = 1'b1;
      tick(); tick();
      n_run++;
      if (act_vec() !== 15'h0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %h, required %h", act_vec(), 15'h0);
      end
   endtask

   task automatic test_pattern();
      logic [7:0] hi;
      int b;
      hi = 8'h00;
      do_reset();
      pattern_en = 1'b1;
      start_frame();
      enable = 1'b0;
      for (int c = 0; c < 140; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c, 1'b1, -1, 16'h0)) begin
            n_fail++;
            $display("FAIL pattern c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c, 1'b1, -1, 16'h0));
         end
         if (dvp_href && c >= 40) begin
            b = (c - 40) % 20;
            if (b % 2 == 0) begin
               hi = dvp_data;
            end else begin
               n_run++;
               if ({hi, dvp_data} !== bar_color(b / 2)) begin
                  n_fail++;
                  $display("FAIL pattern_pixel c=%0d: got %h, required %h", c, {hi, dvp_data},
                           bar_color(b / 2));
               end
            end
         end
         tick();
      end
      n_run++;
      if (act_vec() !== 15'h0) begin
         n_fail++;
         $display("FAIL pattern_idle: got %h, required %h", act_vec(), 15'h0);
      end
   endtask

   task automatic test_stream();
      int nready;
      nready = 0;
      do_reset();
      pix_valid = 1'b1; pix_data = 16'h1234; auto_inc = 1'b1;
      start_frame();
      enable = 1'b0;
      for (int c = 0; c < 140; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c, 1'b0, -1, 16'h1234)) begin
            n_fail++;
            $display("FAIL stream c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c, 1'b0, -1, 16'h1234));
         end
         if (c >= 39 && c < 59 && pix_ready) nready++;
         tick();
      end
      n_run++;
      if (nready !== 8) begin
         n_fail++;
         $display("FAIL stream_ready_count: got %0d, required %0d", nready, 8);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      pix_valid = 1'b1; pix_data = 16'h1234; auto_inc = 1'b1;
      start_frame();
      enable = 1'b0;
      for (int c = 0; c < 140; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c, 1'b0, 2, 16'h1234)) begin
            n_fail++;
            $display("FAIL underflow c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c, 1'b0, 2, 16'h1234));
         end
         pix_valid = (c != 43);
         tick();
      end
      n_run++;
      if (act_vec() !== 15'h0001) begin
         n_fail++;
         $display("FAIL underflow_sticky: got %h, required %h", act_vec(), 15'h0001);
      end
   endtask

   task automatic test_back_to_back();
      int nfs, nfd;
      nfs = 0; nfd = 0;
      do_reset();
      pattern_en = 1'b1;
      start_frame();
      for (int c = 0; c < 280; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c % 140, 1'b1, -1, 16'h0)) begin
            n_fail++;
            $display("FAIL back_to_back c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c % 140, 1'b1, -1, 16'h0));
         end
         if (frame_start) nfs++;
         if (frame_done) nfd++;
         enable = (c < 200);
         tick();
      end
      n_run++;
      if ({nfs, nfd} !== {32'd2, 32'd2}) begin
         n_fail++;
         $display("FAIL back_to_back_pulses: got fs=%0d fd=%0d, required fs=2 fd=2", nfs, nfd);
      end
      n_run++;
      if (act_vec() !== 15'h0) begin
         n_fail++;
         $display("FAIL back_to_back_idle: got %h, required %h", act_vec(), 15'h0);
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      pattern_en = 1'b1;
      start_frame();
      for (int c = 0; c < 140; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c, 1'b1, -1, 16'h0)) begin
            n_fail++;
            $display("FAIL enable_drop c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c, 1'b1, -1, 16'h0));
         end
         enable = (c < 85);
         tick();
      end
      for (int c = 0; c < 40; c++) begin
         n_run++;
         if ({dvp_vsync, busy, frame_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL enable_drop_idle c=%0d: got vsync/busy/fs=%b, required 000", c,
                     {dvp_vsync, busy, frame_start});
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_line();
      do_reset();
      pix_valid = 1'b0;
      start_frame();
      enable = 1'b0;
      repeat (45) tick();
      n_run++;
      if ({dvp_href, underflow, busy} !== 3'b111) begin
         n_fail++;
         $display("FAIL mid_line_precondition: got href/uf/busy=%b, required 111",
                  {dvp_href, underflow, busy});
      end
      Rst_n = 1'b0;
      #1;
      n_run++;
      if (act_vec() !== 15'h0) begin
         n_fail++;
         $display("FAIL mid_line_reset: got %h, required %h", act_vec(), 15'h0);
      end
      enable = 1'b1; pattern_en = 1'b1;
      tick(); tick();
      Rst_n = 1'b1;
      tick();
      enable = 1'b0;
      for (int c = 0; c < 140; c++) begin
         n_run++;
         if (act_vec() !== exp_vec(c, 1'b1, -1, 16'h0)) begin
            n_fail++;
            $display("FAIL post_reset_frame c=%0d: got %h, required %h", c, act_vec(),
                     exp_vec(c, 1'b1, -1, 16'h0));
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_stream();
      test_underflow();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_line();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
